alu_seq: RTL

- Parametrised, multi-cycle successor to the datapath ALU.
- Adds SUB, variable shifts and multiply alongside FWD/ADD/AND/OR.
- Adds a START/BUSY/DONE handshake, and registers RESULT plus status flags (ZERO, CARRY, OVERFLOW).
- Sits between the register file / immediate mux and the writeback path; the control unit stalls the PC while BUSY=1.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_comb.sv | 57 +++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU.
//   - OP_* : 3-bit opcode encodings driven on SELECT.
//   - state_t : control FSM states (IDLE waits for START, EXEC runs the
//     multi-cycle shift / multiply datapath).
package alu_seq_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU slice.
// Ports:
//   op       : opcode (FWD/ADD/AND/OR/SUB are decoded here)
//   a, b     : operands
//   y        : result
//   carry    : ADD carry-out, SUB borrow (a < b unsigned), 0 otherwise
//   overflow : ADD/SUB signed overflow, 0 otherwise
// Opcodes not handled here (shifts, MUL) pass operand a through with clear
// flags; that is exactly the result of a shift by zero, which the top
// completes in a single cycle.
module alu_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit catches the carry-out of ADD and the borrow of SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y        = a;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_FWD: y = b;
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        y        = a;
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with START/BUSY/DONE handshake and registered result/flags.
// Ports:
//   CLK, RESET     : clock; synchronous active-high reset
//   START          : request, accepted on an edge where BUSY=0
//   SELECT         : opcode (see alu_seq_pkg)
//   DATA1, DATA2   : operand A / shift source / multiplicand,
//                    operand B / shift amount / multiplier
//   BUSY           : multi-cycle operation in progress
//   DONE           : one-cycle pulse, RESULT and flags were just updated
//   RESULT         : registered result, held until the next DONE
//   ZERO, CARRY, OVERFLOW : status flags registered with RESULT
//   dbg_state      : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where START=1 and BUSY=0;
// SELECT/DATA1/DATA2 are captured on that edge only. START while BUSY=1 is
// dropped, not queued. DONE rises for exactly one cycle per accepted request,
// and BUSY is already low in that cycle, so a new START can be accepted there.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW,
  output state_t           dbg_state
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t state, state_next;

  logic [SHW-1:0]     cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;

  logic [SHW-1:0]     amt;
  logic               is_mul;
  logic               is_shift;
  logic               is_multi;
  logic               load_single;
  logic               load_exec;
  logic               finish;

  logic [WIDTH-1:0]   comb_y;
  logic               comb_carry;
  logic               comb_ovf;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   sh_next;
  logic [2*WIDTH-1:0] step;

  logic [WIDTH-1:0]   result_q;
  logic               done_q;
  logic               zero_q;
  logic               carry_q;
  logic               ovf_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (SELECT),
    .a        (DATA1),
    .b        (DATA2),
    .y        (comb_y),
    .carry    (comb_carry),
    .overflow (comb_ovf)
  );

  // Any shift amount of WIDTH or more behaves like WIDTH: SLL empties the
  // word, SRA fills it with the sign bit.
  assign amt      = (DATA2 >= WIDTH_V) ? SHW'(WIDTH) : DATA2[SHW-1:0];
  assign is_mul   = (SELECT == OP_MUL);
  assign is_shift = (SELECT == OP_SLL) || (SELECT == OP_SRA);
  assign is_multi = is_mul || (is_shift && (amt != '0));

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  // Each step adds the multiplicand into the upper half when the current
  // multiplier LSB is set, then shifts the whole accumulator right by one.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};

  // Shift operand lives in the low half of acc; one bit per edge.
  assign sh_next = (op_q == OP_SLL) ? {acc[WIDTH-2:0], 1'b0}
                                    : {acc[WIDTH-1], acc[WIDTH-1:1]};

  assign step = (op_q == OP_MUL) ? {mul_sum, acc[WIDTH-1:1]}
                                 : {{WIDTH{1'b0}}, sh_next};

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_single = 1'b0;
    load_exec   = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          if (is_multi) begin
            load_exec  = 1'b1;
            state_next = EXEC;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt == SHW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      op_q     <= OP_FWD;
      mcand    <= '0;
      acc      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (load_single) begin
        result_q <= comb_y;
        zero_q   <= (comb_y == '0);
        carry_q  <= comb_carry;
        ovf_q    <= comb_ovf;
        done_q   <= 1'b1;
      end

      if (load_exec) begin
        op_q  <= SELECT;
        cnt   <= is_mul ? SHW'(WIDTH) : amt;
        mcand <= DATA1;
        acc   <= {{WIDTH{1'b0}}, (is_mul ? DATA2 : DATA1)};
      end

      if (state == EXEC) begin
        acc <= step;
        cnt <= cnt - SHW'(1);
      end

      if (finish) begin
        result_q <= step[WIDTH-1:0];
        zero_q   <= (step[WIDTH-1:0] == '0);
        carry_q  <= 1'b0;
        ovf_q    <= (op_q == OP_MUL) ? (step[2*WIDTH-1:WIDTH] != '0) : 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  assign BUSY      = (state == EXEC);
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign ZERO      = zero_q;
  assign CARRY     = carry_q;
  assign OVERFLOW  = ovf_q;
  assign dbg_state = state;

endmodule
